// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-miss, D-miss and write-through stores onto one pipelined memory,
// runs 8-word block fills into the chosen cache. Optional counters: FILL_STATS_EN.
`timescale 1ns/1ps
module cache_fill_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_miss,
  input  logic [ADDR_W-1:0]                i_miss_addr,
  input  logic                             d_miss,
  input  logic [ADDR_W-1:0]                d_miss_addr,
  input  logic                             d_wr_req,
  input  logic [ADDR_W-1:0]                d_wr_addr,
  input  logic [DATA_W-1:0]                d_wr_data,
  output logic                             d_wr_ack,
  output logic                             i_busy,
  output logic                             d_busy,
  output logic                             fill_sel,
  output logic                             fill_we,
  output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word,
  output logic [DATA_W-1:0]                fill_data,
  output logic                             tag_we,
  output logic                             fill_done,
  output logic                             mem_en,
  output logic                             mem_wr,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
`ifdef FILL_STATS_EN
  output logic [15:0]                      i_fill_cnt,
  output logic [15:0]                      d_fill_cnt,
  output logic [15:0]                      wr_cnt,
`endif
  input  logic [DATA_W-1:0]                mem_rdata,
  input  logic                             mem_valid
);

  localparam int WORD_W         = $clog2(WORDS_PER_BLK);
  localparam int CNT_W          = WORD_W + 1;
  localparam int BYTES_PER_WORD = DATA_W / 8;
  localparam int OFF_W          = $clog2(WORDS_PER_BLK * BYTES_PER_WORD);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_e;

  state_e              state_q, state_d;
  logic                fill_sel_q, fill_sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;     // store address or fill block base
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    ic_q, ic_d;         // words issued, stops at WORDS_PER_BLK
  logic [WORD_W-1:0]   rc_q, rc_d;         // words received
  logic                issuing;
  logic                last_word;

  assign issuing   = (ic_q < CNT_W'(WORDS_PER_BLK));
  assign last_word = (rc_q == WORD_W'(WORDS_PER_BLK - 1));

  // NOTE: sequential state uses non-blocking assignments only; next-state
  // values come from the combinational process below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_sel_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_q       <= '0;
      rc_q       <= '0;
    end else begin
      state_q    <= state_d;
      fill_sel_q <= fill_sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_q       <= ic_d;
      rc_q       <= rc_d;
    end
  end

  // NOTE: every variable gets a default at the top so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fill_sel_d = fill_sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_d       = ic_q;
    rc_d       = rc_q;
    unique case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          addr_d  = d_wr_addr;
          wdata_d = d_wr_data;
          state_d = WRITE;
        end else if (d_miss || i_miss) begin
          addr_d     = (d_miss ? d_miss_addr : i_miss_addr) & BLK_MASK;
          fill_sel_d = d_miss;
          ic_d       = '0;
          rc_d       = '0;
          state_d    = FILL;
        end
      end
      WRITE: state_d = IDLE;
      FILL: begin
        if (issuing) ic_d = ic_q + CNT_W'(1);
        if (mem_valid) begin
          rc_d = rc_q + WORD_W'(1);
          if (last_word) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while rst_n is held, even for pass-through terms.
  always_comb begin
    d_wr_ack  = 1'b0;
    fill_we   = 1'b0;
    fill_word = '0;
    fill_data = '0;
    tag_we    = 1'b0;
    fill_done = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_busy    = 1'b0;
    d_busy    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE:  d_wr_ack = d_wr_req;
        WRITE: begin
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        FILL: begin
          mem_en = issuing;
          if (issuing) mem_addr = addr_q + ADDR_W'(ic_q) * ADDR_W'(BYTES_PER_WORD);
          if (mem_valid) begin
            fill_we   = 1'b1;
            fill_word = rc_q;
            fill_data = mem_rdata;
            tag_we    = last_word;
          end
        end
        DONE:    fill_done = 1'b1;
        default: ;
      endcase
      i_busy = i_miss | ((state_q != IDLE) & ~fill_sel_q);
      d_busy = d_miss | (d_wr_req & ~d_wr_ack) |
               (((state_q == FILL) | (state_q == DONE)) & fill_sel_q);
    end
  end

  assign fill_sel = fill_sel_q;

`ifdef FILL_STATS_EN
  logic [15:0] i_fill_cnt_q, d_fill_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_fill_cnt_q <= '0;
      d_fill_cnt_q <= '0;
      wr_cnt_q     <= '0;
    end else begin
      if (fill_done && !fill_sel_q && i_fill_cnt_q != 16'hFFFF) i_fill_cnt_q <= i_fill_cnt_q + 16'd1;
      if (fill_done &&  fill_sel_q && d_fill_cnt_q != 16'hFFFF) d_fill_cnt_q <= d_fill_cnt_q + 16'd1;
      if (d_wr_ack && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign i_fill_cnt = i_fill_cnt_q;
  assign d_fill_cnt = d_fill_cnt_q;
  assign wr_cnt     = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a 4-cycle pipelined memory model.
`timescale 1ns/1ps
module tb_cache_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack, i_busy, d_busy, fill_sel, fill_we, tag_we, fill_done;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef FILL_STATS_EN
  logic [15:0] i_fill_cnt, d_fill_cnt, wr_cnt;
`endif

  always #5 clk = ~clk;

  cache_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ack(d_wr_ack), .i_busy(i_busy), .d_busy(d_busy),
    .fill_sel(fill_sel), .fill_we(fill_we), .fill_word(fill_word),
    .fill_data(fill_data), .tag_we(tag_we), .fill_done(fill_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef FILL_STATS_EN
    .i_fill_cnt(i_fill_cnt), .d_fill_cnt(d_fill_cnt), .wr_cnt(wr_cnt),
`endif
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return {4'b0, d_wr_ack, i_busy, d_busy, fill_sel, fill_we, fill_word, fill_data,
            tag_we, fill_done, mem_en, mem_wr, mem_addr, mem_wdata};
  endfunction

  // Memory: a read issued in cycle k returns 0xA000 + word-in-block in cycle k+4.
  logic        vp[4];
  logic [15:0] va[4];
  logic        iss_v, inject;
  logic [15:0] iss_a;

  task automatic upd_mem();
    mem_valid = vp[3] | inject;
    mem_rdata = inject ? 16'h5555 : (vp[3] ? 16'hA000 + {13'b0, va[3][3:1]} : 16'h0000);
  endtask

  // Called after the negedge checks: captures this cycle's issue, then moves
  // to just after the next rising edge.
  task automatic tick();
    iss_v = rst_n & mem_en & ~mem_wr;
    iss_a = mem_addr;
    @(posedge clk);
    #1;
    for (int i = 3; i > 0; i--) begin
      vp[i] = vp[i-1];
      va[i] = va[i-1];
    end
    vp[0] = iss_v;
    va[0] = iss_a;
    upd_mem();
  endtask

  // Full miss from IDLE: grant cycle 0, first issue cycle 1, fill_done cycle 13.
  task automatic run_fill(input logic is_d, input logic [15:0] addr, input string tag);
    int   first_iss = -1;
    int   done_at   = -1;
    int   n_we      = 0;
    int   words_ok  = 0;
    logic tag_seen;
    if (is_d) begin d_miss = 1'b1; d_miss_addr = addr; end
    else      begin i_miss = 1'b1; i_miss_addr = addr; end
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      @(negedge clk);
      if (mem_en && !mem_wr && first_iss < 0) begin
        first_iss = c;
        check({tag, " first addr"}, mem_addr, addr & 16'hFFF0);
      end
      if (fill_we) begin
        if (fill_sel == is_d && fill_word == 3'(n_we) && fill_data == 16'hA000 + {13'b0, fill_word})
          words_ok++;
        n_we++;
      end
      if (fill_done) done_at = c;
      tag_seen = tag_we;
      tick();
      if (tag_seen) begin
        if (is_d) d_miss = 1'b0;
        else      i_miss = 1'b0;
      end
    end
    check({tag, " first issue cycle"}, 64'(first_iss), 64'd1);
    check({tag, " words ok"},          64'(words_ok),  64'd8);
    check({tag, " fill_done cycle"},   64'(done_at),   64'd13);
  endtask

  task automatic do_store(input logic [15:0] addr, input logic [15:0] data);
    d_wr_req = 1'b1; d_wr_addr = addr; d_wr_data = data;
    @(negedge clk);
    check("store ack", d_wr_ack, 1'b1);
    tick();
    d_wr_req = 1'b0;
    @(negedge clk);
    check("store mem", {mem_en, mem_wr, mem_addr, mem_wdata}, {1'b1, 1'b1, addr, data});
    tick();
  endtask

  typedef struct packed {
    logic        i_miss;
    logic        en;
    logic [15:0] addr;
    logic        we;
    logic [2:0]  word;
    logic [15:0] data;
    logic        tag;
    logic        done;
    logic        ibusy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // I-miss at 0x1236, one row per cycle starting with the grant cycle.
    tbl = '{
      '{1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 16'h1238, 1'b1, 3'd0, 16'hA000, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 16'h123A, 1'b1, 3'd1, 16'hA001, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 16'h123C, 1'b1, 3'd2, 16'hA002, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 16'h123E, 1'b1, 3'd3, 16'hA003, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd4, 16'hA004, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 16'hA005, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 16'hA006, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 16'hA007, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0}
    };

    for (int i = 0; i < 4; i++) begin vp[i] = 1'b0; va[i] = 16'h0; end
    inject = 1'b0;
    upd_mem();
    rst_n = 1'b0;
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    d_miss = 1'b1; d_miss_addr = 16'h8010;
    d_wr_req = 1'b1; d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF;

    // Reset: outputs low even with every request asserted.
    #12;
    check("outputs in reset", outs(), 64'h0);
    i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", outs(), 64'h0);
`ifdef FILL_STATS_EN
    check("stats after reset", {i_fill_cnt, d_fill_cnt, wr_cnt}, 48'h0);
`endif
    tick();

    // Single I-miss, cycle by cycle.
    for (int r = 0; r < 15; r++) begin
      i_miss = tbl[r].i_miss;
      i_miss_addr = 16'h1236;
      @(negedge clk);
      check($sformatf("r%0d mem_en", r), mem_en, tbl[r].en);
      check($sformatf("r%0d mem_wr", r), mem_wr, 1'b0);
      if (tbl[r].en) check($sformatf("r%0d mem_addr", r), mem_addr, tbl[r].addr);
      check($sformatf("r%0d fill_we", r), fill_we, tbl[r].we);
      if (tbl[r].we) check($sformatf("r%0d word/data", r), {fill_word, fill_data}, {tbl[r].word, tbl[r].data});
      check($sformatf("r%0d tag_we", r), tag_we, tbl[r].tag);
      check($sformatf("r%0d fill_done", r), fill_done, tbl[r].done);
      check($sformatf("r%0d i_busy", r), i_busy, tbl[r].ibusy);
      check($sformatf("r%0d d_busy/sel", r), {d_busy, fill_sel}, 2'b00);
      tick();
    end

    // Simultaneous misses: D served first, I stays stalled until its own fill ends.
    begin
      int d_done = -1, i_done = -1, ib_low = 0, d_ok = 0, i_ok = 0;
      logic [15:0] d_first = 16'hFFFF, i_first = 16'hFFFF;
      logic t_seen, t_sel;
      i_miss = 1'b1; i_miss_addr = 16'h0040;
      d_miss = 1'b1; d_miss_addr = 16'h8010;
      for (int c = 0; c < 60 && i_done < 0; c++) begin
        @(negedge clk);
        if (!i_busy) ib_low++;
        if (mem_en && !mem_wr) begin
          if (fill_sel && d_first == 16'hFFFF) d_first = mem_addr;
          if (!fill_sel && i_first == 16'hFFFF) i_first = mem_addr;
        end
        if (fill_we && fill_data == 16'hA000 + {13'b0, fill_word}) begin
          if (fill_sel) d_ok++;
          else          i_ok++;
        end
        if (fill_done) begin
          if (fill_sel) d_done = c;
          else          i_done = c;
        end
        t_seen = tag_we;
        t_sel  = fill_sel;
        tick();
        if (t_seen) begin
          if (t_sel) d_miss = 1'b0;
          else       i_miss = 1'b0;
        end
      end
      check("dual d first addr", d_first, 16'h8010);
      check("dual i first addr", i_first, 16'h0040);
      check("dual d done cycle", 64'(d_done), 64'd13);
      check("dual i done cycle", 64'(i_done), 64'd27);
      check("dual words", {32'(d_ok), 32'(i_ok)}, {32'd8, 32'd8});
      check("dual i_busy held", 64'(ib_low), 64'd0);
      @(negedge clk);
      check("dual i_busy released", i_busy, 1'b0);
      tick();
    end

    // Store beats a pending D-miss; the fill follows once the write is out.
    d_wr_req = 1'b1; d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF;
    d_miss = 1'b1; d_miss_addr = 16'h200A;
    @(negedge clk);
    check("wr ack same cycle", {d_wr_ack, mem_en, d_busy}, 3'b101);
    tick();
    d_wr_req = 1'b0;
    @(negedge clk);
    check("wr mem cycle", {mem_en, mem_wr, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h2002, 16'hBEEF});
    check("wr no ack", d_wr_ack, 1'b0);
    tick();
    run_fill(1'b1, 16'h200A, "d after wr");

    // Unsolicited mem_valid while idle must not write the arrays.
    inject = 1'b1;
    upd_mem();
    @(negedge clk);
    check("idle valid ignored", {fill_we, tag_we, fill_done}, 3'b000);
    check("idle not busy", {i_busy, d_busy}, 2'b00);
    inject = 1'b0;
    tick();

    // Reset after three words: immediate quiet, stale returns dropped, clean restart.
    begin
      int n = 0, stale = 0, quiet_bad = 0;
      i_miss = 1'b1; i_miss_addr = 16'h1236;
      for (int c = 0; c < 40 && n < 3; c++) begin
        @(negedge clk);
        if (fill_we) n++;
        tick();
      end
      check("words before reset", 64'(n), 64'd3);
      rst_n = 1'b0;
      #1;
      check("outputs at reset", outs(), 64'h0);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (outs() != 64'h0) quiet_bad++;
        tick();
      end
      check("outputs held in reset", 64'(quiet_bad), 64'd0);
      i_miss = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (fill_we || tag_we || fill_done || mem_en) stale++;
        tick();
      end
      check("stale valid ignored", 64'(stale), 64'd0);
      check("sel cleared by reset", fill_sel, 1'b0);
      run_fill(1'b0, 16'h1236, "i restart");
    end

    // Extra traffic for the statistics counters.
    run_fill(1'b0, 16'h0100, "i second");
    run_fill(1'b1, 16'h3456, "d second");
    do_store(16'h4000, 16'h1111);
    do_store(16'h4002, 16'h2222);
    do_store(16'h4004, 16'h3333);
`ifdef FILL_STATS_EN
    @(negedge clk);
    check("i_fill_cnt", i_fill_cnt, 16'd2);
    check("d_fill_cnt", d_fill_cnt, 16'd1);
    check("wr_cnt", wr_cnt, 16'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
